decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
// - Parametrised ARM decode stage with its ID/EX pipeline register built in.
// - Holds the register file with write-through bypass and decodes control fields.
// - Checks the condition code, detects data hazards internally, and presents a registered valid/ready bundle to EXE.
// - Sits between IF/ID and EXE; replaces the external hazard input and the separate ID/EX register.
// PARAMETERS
// - DATA_W   32  register and operand width
// - REG_CNT  16  number of architectural registers; AW = $clog2(REG_CNT)
// - BYPASS   1   1: a WB write to the register being read returns wb_value in the same cycle
// - FWD_EN   1   1: EXE has forwarding, so stall on load-use only; 0: stall on any EXE/MEM RAW
// PORTS
// - clk            in   1       rising-edge clock
// - rst            in   1       synchronous, active-high reset
// - in_valid       in   1       IF/ID holds a valid instruction
// - in_ready       out  1       decode accepts instr this cycle
// - instr          in   32      ARM instruction word
// - pc_in          in   32      PC of instr
// - status         in   4       NZCV flags from the status register
// - flush          in   1       branch taken: kill the decode slot and the output register
// - wb_en          in   1       write-back enable
// - wb_dest        in   AW      write-back register index
// - wb_value       in   DATA_W  write-back data
// - exe_dest, mem_dest         in  AW  destination register of the EXE / MEM stage
// - exe_wb_en, mem_wb_en       in  1   destination write enable of the EXE / MEM stage
// - exe_mem_r_en   in   1       EXE stage instruction is a load
// - out_ready      in   1       EXE can accept a new bundle
// - out_valid      out  1       output bundle is valid
// - exec_cmd       out  4       ALU command
// - mem_r_en, mem_w_en, wb_en_out, s_out, b_out   out  1   control bits
// - imm            out  1       instr[25]
// - dest, src_1, src_2         out  AW  Rd, Rn, and Rm (or Rd for stores)
// - val_rn, val_rm out  DATA_W  operand values
// - shift_operand  out  12      instr[11:0]
// - imm24          out  24      instr[23:0]
// - pc_out         out  32      registered PC
// BEHAVIOUR
// - Reset (sync): all output registers 0, out_valid = 0, every register-file entry = 0.
// - Reset has priority over all other events, including mid-stall and mid-flush.
// - Register file: written at posedge when wb_en=1; a wb_dest >= REG_CNT is ignored.
// - Register-file reads are combinational. With BYPASS=1, wb_en && wb_dest==addr returns wb_value.
// - src_2 = mem_w_en ? instr[15:12] : instr[3:0].
// - two_src = ~instr[25] | store.
// - use_rn is 0 for branches (mode 2'b10); otherwise 1.
// - RAW match: (src_1 when use_rn) or (src_2 when two_src) equals a stage dest whose wb_en is set.
// - hazard when FWD_EN=1: in_valid & exe_mem_r_en & exe_wb_en & match(exe_dest).
// - hazard when FWD_EN=0: in_valid & (exe_wb_en & match(exe_dest) | mem_wb_en & match(mem_dest)).
// - advance = ~out_valid | out_ready.
// - in_ready = advance & ~hazard & ~flush.
// - Output register update, in priority order:
//   - flush: out_valid <= 0 and control bits <= 0.
//   - else advance & hazard: insert a bubble (out_valid <= 0).
//   - else advance: capture the bundle and set out_valid <= in_valid.
//   - else hold every output unchanged.
// - Condition check runs on instr[31:28] vs status in the capture cycle. On failure: out_valid=1, all enables/b/s = 0 (a NOP that still occupies the slot).
// - Latency: 1 cycle from acceptance to out_valid. Throughput: 1 instruction per cycle with no hazard or backpressure.
// - WB write and read of the same register in the capture cycle: the new value is captured when BYPASS=1 and the old value when BYPASS=0.
// STRUCTURE
// - Package arm_pkg holds the exec_cmd encodings, mode codes, cond codes, and a ctrl_t packed struct {exec_cmd, mem_r_en, mem_w_en, wb_en, s, b}.
// - Sub-module reg_file_bypass #(DATA_W, REG_CNT, BYPASS): 2 read ports, 1 write port, sync reset.
// - The existing control unit and condition check are instantiated unchanged.
// TESTING
// - Reset, then write R3=0x5 via WB; decode ADD R1,R3,R2 (cond AL) -> next cycle val_rn=0x5, out_valid=1, exec_cmd=ADD.
// - Same-cycle WB R4=0xAA while decoding a read of R4 -> BYPASS=1 gives val_rm=0xAA; BYPASS=0 gives the old 0.
// - FWD_EN=1, EXE is LDR R2 and decode reads R2 -> in_ready=0 and a 1-cycle bubble (out_valid=0), then the instruction issues.
// - FWD_EN=1 with a non-load in EXE writing R2 -> no stall.
// - Z=0 with MOVEQ -> out_valid=1, wb_en_out=0, mem_w_en=0.
// - out_ready=0 for 3 cycles -> outputs frozen and in_ready=0.
// - Flush during the stall -> out_valid=0 next cycle.
// - Assert rst mid-stream -> out_valid=0 and all registers read 0 afterwards.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM decode slice: ALU commands, instruction modes,
// condition codes and the packed control bundle produced by the control unit.
package arm_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10
  } mode_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic [3:0] exec_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       s;
    logic       b;
  } ctrl_t;

  // A failed condition keeps the ALU command but drops every side effect.
  function automatic ctrl_t squash_ctrl(input ctrl_t c);
    ctrl_t r;
    r          = '0;
    r.exec_cmd = c.exec_cmd;
    return r;
  endfunction

endpackage

// File: rtl/condition_check.sv
// Evaluates an ARM condition field against the NZCV flags.
module condition_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = status;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Decodes mode/opcode/S into the ALU command and the memory/write-back/branch
// control bits.
module control_unit
  import arm_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_bit,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_DP: begin
        ctrl.s     = s_bit;
        ctrl.wb_en = 1'b1;
        case (opcode)
          OP_MOV:  ctrl.exec_cmd = CMD_MOV;
          OP_MVN:  ctrl.exec_cmd = CMD_MVN;
          OP_ADD:  ctrl.exec_cmd = CMD_ADD;
          OP_ADC:  ctrl.exec_cmd = CMD_ADC;
          OP_SUB:  ctrl.exec_cmd = CMD_SUB;
          OP_SBC:  ctrl.exec_cmd = CMD_SBC;
          OP_AND:  ctrl.exec_cmd = CMD_AND;
          OP_ORR:  ctrl.exec_cmd = CMD_ORR;
          OP_EOR:  ctrl.exec_cmd = CMD_EOR;
          OP_CMP: begin
            ctrl.exec_cmd = CMD_SUB;
            ctrl.wb_en    = 1'b0;
          end
          OP_TST: begin
            ctrl.exec_cmd = CMD_AND;
            ctrl.wb_en    = 1'b0;
          end
          default: begin
            ctrl.wb_en = 1'b0;
            ctrl.s     = 1'b0;
          end
        endcase
      end
      // L bit selects load vs store; both compute base + offset.
      MODE_MEM: begin
        ctrl.exec_cmd = CMD_ADD;
        if (s_bit) begin
          ctrl.mem_r_en = 1'b1;
          ctrl.wb_en    = 1'b1;
        end else begin
          ctrl.mem_w_en = 1'b1;
        end
      end
      MODE_BR: ctrl.b = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_file_bypass.sv
// Register file with two combinational read ports, one write port and an
// optional write-through path so a same-cycle write is visible to readers.
module reg_file_bypass #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_addr_1,
  input  logic [AW-1:0]     rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam logic [AW:0] CNT = (AW + 1)'(REG_CNT);

  logic [DATA_W-1:0] regs [REG_CNT];
  logic              wr_ok;

  // Indices beyond the populated range are dropped rather than aliased.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_1 = '0;
    if ({1'b0, rd_addr_1} < CNT) rd_data_1 = regs[rd_addr_1];
    if (BYPASS && wr_ok && (wr_addr == rd_addr_1)) rd_data_1 = wr_data;
  end

  always_comb begin
    rd_data_2 = '0;
    if ({1'b0, rd_addr_2} < CNT) rd_data_2 = regs[rd_addr_2];
    if (BYPASS && wr_ok && (wr_addr == rd_addr_2)) rd_data_2 = wr_data;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// ARM decode stage with built-in hazard detection and the ID/EX register,
// handing a registered valid/ready bundle to EXE.
module decode_stage_pipe
  import arm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter bit BYPASS  = 1'b1,
  parameter bit FWD_EN  = 1'b1,
  localparam int AW     = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc_in,
  input  logic [3:0]        status,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [AW-1:0]     exe_dest,
  input  logic [AW-1:0]     mem_dest,
  input  logic              exe_wb_en,
  input  logic              mem_wb_en,
  input  logic              exe_mem_r_en,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [3:0]        exec_cmd,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en_out,
  output logic              s_out,
  output logic              b_out,
  output logic              imm,
  output logic [AW-1:0]     dest,
  output logic [AW-1:0]     src_1,
  output logic [AW-1:0]     src_2,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       imm24,
  output logic [31:0]       pc_out
);

  ctrl_t             dec_ctrl;
  ctrl_t             out_ctrl;
  logic              cond_pass;
  logic [AW-1:0]     src_1_d, src_2_d, dest_d;
  logic [DATA_W-1:0] rn_data, rm_data;
  logic              use_rn, two_src;
  logic              exe_match, mem_match;
  logic              hazard, advance;

  control_unit u_control_unit (
    .mode   (instr[27:26]),
    .opcode (instr[24:21]),
    .s_bit  (instr[20]),
    .ctrl   (dec_ctrl)
  );

  condition_check u_condition_check (
    .cond   (instr[31:28]),
    .status (status),
    .pass   (cond_pass)
  );

  // Stores read Rd as the data to write, so it replaces Rm on port 2.
  assign src_1_d = AW'(instr[19:16]);
  assign dest_d  = AW'(instr[15:12]);
  assign src_2_d = dec_ctrl.mem_w_en ? AW'(instr[15:12]) : AW'(instr[3:0]);
  assign use_rn  = (instr[27:26] != MODE_BR);
  assign two_src = ~instr[25] | dec_ctrl.mem_w_en;

  reg_file_bypass #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .BYPASS  (BYPASS)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_1 (src_1_d),
    .rd_addr_2 (src_2_d),
    .rd_data_1 (rn_data),
    .rd_data_2 (rm_data),
    .wr_en     (wb_en),
    .wr_addr   (wb_dest),
    .wr_data   (wb_value)
  );

  assign exe_match = exe_wb_en && ((use_rn && (src_1_d == exe_dest)) ||
                                   (two_src && (src_2_d == exe_dest)));
  assign mem_match = mem_wb_en && ((use_rn && (src_1_d == mem_dest)) ||
                                   (two_src && (src_2_d == mem_dest)));

  // With forwarding only a load result is still unavailable to the next op.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN) hazard = in_valid && exe_mem_r_en && exe_match;
    else        hazard = in_valid && (exe_match || mem_match);
  end

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~hazard & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_ctrl      <= '0;
      imm           <= 1'b0;
      dest          <= '0;
      src_1         <= '0;
      src_2         <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      shift_operand <= '0;
      imm24         <= '0;
      pc_out        <= '0;
    end else if (flush || (advance && hazard)) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (advance) begin
      out_valid     <= in_valid;
      out_ctrl      <= cond_pass ? dec_ctrl : squash_ctrl(dec_ctrl);
      imm           <= instr[25];
      dest          <= dest_d;
      src_1         <= src_1_d;
      src_2         <= src_2_d;
      val_rn        <= rn_data;
      val_rm        <= rm_data;
      shift_operand <= instr[11:0];
      imm24         <= instr[23:0];
      pc_out        <= pc_in;
    end
  end

  assign exec_cmd  = out_ctrl.exec_cmd;
  assign mem_r_en  = out_ctrl.mem_r_en;
  assign mem_w_en  = out_ctrl.mem_w_en;
  assign wb_en_out = out_ctrl.wb_en;
  assign s_out     = out_ctrl.s;
  assign b_out     = out_ctrl.b;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a bypass+forwarding instance and a
// no-bypass/no-forwarding instance share one stimulus stream.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, wb_en, out_ready;
  logic [31:0] instr, pc_in;
  logic [3:0]  status;
  logic [3:0]  wb_dest, exe_dest, mem_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en, mem_wb_en, exe_mem_r_en;

  logic        in_ready, out_valid, mem_r_en, mem_w_en, wb_en_out, s_out, b_out, imm;
  logic [3:0]  exec_cmd, dest, src_1, src_2;
  logic [31:0] val_rn, val_rm, pc_out;
  logic [11:0] shift_operand;
  logic [23:0] imm24;

  logic        b_in_ready, b_out_valid, b_mem_r_en, b_mem_w_en, b_wb_en_out, b_s_out, b_b_out, b_imm;
  logic [3:0]  b_exec_cmd, b_dest, b_src_1, b_src_2;
  logic [31:0] b_val_rn, b_val_rm, b_pc_out;
  logic [11:0] b_shift_operand;
  logic [23:0] b_imm24;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(32), .REG_CNT(16), .BYPASS(1'b1), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc_in(pc_in), .status(status), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en),
    .mem_wb_en(mem_wb_en), .exe_mem_r_en(exe_mem_r_en), .out_ready(out_ready),
    .out_valid(out_valid), .exec_cmd(exec_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en_out(wb_en_out), .s_out(s_out), .b_out(b_out), .imm(imm), .dest(dest),
    .src_1(src_1), .src_2(src_2), .val_rn(val_rn), .val_rm(val_rm),
    .shift_operand(shift_operand), .imm24(imm24), .pc_out(pc_out)
  );

  decode_stage_pipe #(.DATA_W(32), .REG_CNT(16), .BYPASS(1'b0), .FWD_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
    .pc_in(pc_in), .status(status), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en),
    .mem_wb_en(mem_wb_en), .exe_mem_r_en(exe_mem_r_en), .out_ready(out_ready),
    .out_valid(b_out_valid), .exec_cmd(b_exec_cmd), .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en),
    .wb_en_out(b_wb_en_out), .s_out(b_s_out), .b_out(b_b_out), .imm(b_imm), .dest(b_dest),
    .src_1(b_src_1), .src_2(b_src_2), .val_rn(b_val_rn), .val_rm(b_val_rm),
    .shift_operand(b_shift_operand), .imm24(b_imm24), .pc_out(b_pc_out)
  );

  // Step to just after the next rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    instr    = ins;
    pc_in    = pc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
      else begin
        fail_count++;
        $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; status = 4'h0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    exe_dest = '0; mem_dest = '0; exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'h1);
    checkOutput("reset_pc_out",    pc_out,         32'h0);
    checkOutput("reset_exec_cmd",  32'(exec_cmd),  32'h0);

    // R3 = 5, then ADD R1,R3,R2
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h5;
    tick();
    wb_en = 1'b0;
    applyStimulus(1'b1, 32'hE0831002, 32'h100);
    #1;
    checkOutput("add_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("add_out_valid", 32'(out_valid), 32'h1);
    checkOutput("add_exec_cmd",  32'(exec_cmd),  32'h2);
    checkOutput("add_val_rn",    val_rn,         32'h5);
    checkOutput("add_val_rm",    val_rm,         32'h0);
    checkOutput("add_dest",      32'(dest),      32'h1);
    checkOutput("add_src_1",     32'(src_1),     32'h3);
    checkOutput("add_src_2",     32'(src_2),     32'h2);
    checkOutput("add_wb_en",     32'(wb_en_out), 32'h1);
    checkOutput("add_pc_out",    pc_out,         32'h100);
    checkOutput("add_shift_op",  32'(shift_operand), 32'h002);

    // ADD R5,R1,R4 while WB writes R4 = 0xAA in the same cycle
    wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'hAA;
    applyStimulus(1'b1, 32'hE0815004, 32'h104);
    tick();
    wb_en = 1'b0;
    checkOutput("bypass_val_rm",    val_rm,   32'hAA);
    checkOutput("no_bypass_val_rm", b_val_rm, 32'h0);

    // Load-use: EXE is LDR R2, decode ADD R6,R2,R3
    exe_dest = 4'd2; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    applyStimulus(1'b1, 32'hE0826003, 32'h108);
    #1;
    checkOutput("load_use_in_ready",   32'(in_ready),   32'h0);
    checkOutput("load_use_in_ready_b", 32'(b_in_ready), 32'h0);
    tick();
    checkOutput("load_use_bubble",   32'(out_valid),   32'h0);
    checkOutput("load_use_bubble_b", 32'(b_out_valid), 32'h0);
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    #1;
    checkOutput("load_use_release", 32'(in_ready), 32'h1);
    tick();
    checkOutput("load_use_issue",  32'(out_valid), 32'h1);
    checkOutput("load_use_pc",     pc_out,         32'h108);
    checkOutput("load_use_val_rm", val_rm,         32'h5);

    // Non-load in EXE writing R2: only the no-forwarding instance stalls
    exe_dest = 4'd2; exe_wb_en = 1'b1;
    applyStimulus(1'b1, 32'hE0826003, 32'h10C);
    #1;
    checkOutput("alu_exe_in_ready",   32'(in_ready),   32'h1);
    checkOutput("alu_exe_in_ready_b", 32'(b_in_ready), 32'h0);
    tick();
    checkOutput("alu_exe_out_valid",   32'(out_valid),   32'h1);
    checkOutput("alu_exe_pc",          pc_out,           32'h10C);
    checkOutput("alu_exe_out_valid_b", 32'(b_out_valid), 32'h0);
    exe_wb_en = 1'b0;
    mem_dest = 4'd3; mem_wb_en = 1'b1;
    #1;
    checkOutput("mem_raw_in_ready",   32'(in_ready),   32'h1);
    checkOutput("mem_raw_in_ready_b", 32'(b_in_ready), 32'h0);
    mem_wb_en = 1'b0;

    // MOVEQ R7,#1 with Z=0 then Z=1
    status = 4'b0000;
    applyStimulus(1'b1, 32'h03A07001, 32'h110);
    tick();
    checkOutput("moveq_fail_valid", 32'(out_valid), 32'h1);
    checkOutput("moveq_fail_wb",    32'(wb_en_out), 32'h0);
    checkOutput("moveq_fail_mem_w", 32'(mem_w_en),  32'h0);
    checkOutput("moveq_imm",        32'(imm),       32'h1);
    status = 4'b0100;
    tick();
    checkOutput("moveq_pass_wb",   32'(wb_en_out), 32'h1);
    checkOutput("moveq_pass_cmd",  32'(exec_cmd),  32'h1);
    checkOutput("moveq_pass_dest", 32'(dest),      32'h7);

    // STR R8,[R1] and LDR R9,[R3]
    applyStimulus(1'b1, 32'hE5818000, 32'h114);
    tick();
    checkOutput("str_mem_w", 32'(mem_w_en),  32'h1);
    checkOutput("str_wb",    32'(wb_en_out), 32'h0);
    checkOutput("str_src_2", 32'(src_2),     32'h8);
    applyStimulus(1'b1, 32'hE5939000, 32'h118);
    tick();
    checkOutput("ldr_mem_r",  32'(mem_r_en),  32'h1);
    checkOutput("ldr_wb",     32'(wb_en_out), 32'h1);
    checkOutput("ldr_val_rn", val_rn,         32'h5);

    // Branch ignores register operands, so a load to R0 in EXE does not stall it
    exe_dest = 4'd0; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    applyStimulus(1'b1, 32'hEA000010, 32'h11C);
    #1;
    checkOutput("branch_no_stall", 32'(in_ready), 32'h1);
    tick();
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    checkOutput("branch_b",     32'(b_out),     32'h1);
    checkOutput("branch_imm24", 32'(imm24),     32'h10);
    checkOutput("branch_wb",    32'(wb_en_out), 32'h0);

    // Backpressure for three cycles, then flush during the stall
    applyStimulus(1'b1, 32'hE0831002, 32'h200);
    tick();
    checkOutput("bp_first_pc", pc_out, 32'h200);
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hE0815004, 32'h204);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      checkOutput("bp_hold_pc",    pc_out,         32'h200);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'h0);
    checkOutput("flush_wb",        32'(wb_en_out), 32'h0);
    out_ready = 1'b1;
    #1;
    checkOutput("post_flush_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("post_flush_pc",    pc_out,         32'h204);
    checkOutput("post_flush_valid", 32'(out_valid), 32'h1);
    applyStimulus(1'b0, 32'hE0831002, 32'h208);
    tick();
    checkOutput("idle_out_valid", 32'(out_valid), 32'h0);

    // Reset mid-stream clears the output register and the register file
    applyStimulus(1'b1, 32'hE0831002, 32'h300);
    tick();
    checkOutput("pre_reset_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("mid_reset_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_reset_pc",    pc_out,         32'h0);
    applyStimulus(1'b1, 32'hE0835004, 32'h304);
    tick();
    checkOutput("after_reset_valid",  32'(out_valid), 32'h1);
    checkOutput("after_reset_val_rn", val_rn,         32'h0);
    checkOutput("after_reset_val_rm", val_rm,         32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
